// File: rtl/trace_pkg.sv
// Shared types and constants for the instruction trace capture unit.
// Contents:
//   state_t      capture FSM state encoding (IDLE/ARMED/CAPTURE/DONE)
//   trace_rec_t  one captured instruction record (122 bits)
//   rec_word()   selects one of the four 32-bit words of a record
package trace_pkg;

  localparam int WORDS_PER_REC = 4;
  localparam int TS_W          = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic [31:0]     data;
    logic [TS_W-1:0] ts;
    logic            mem_we;
    logic            rd_wen;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  // Word order on the output stream: pc, inst, data, {ts, flags}.
  function automatic logic [31:0] rec_word(input trace_rec_t rec, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = rec.pc;
      2'd1:    w = rec.inst;
      2'd2:    w = rec.data;
      default: w = {rec.ts, 6'b0, rec.mem_we, rec.rd_wen};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock record FIFO.
// Ports:
//   clk, reset      clock, async active-low reset (clears pointers and count)
//   push, push_data write request and record; ignored while full
//   pop, head       read request (ignored while empty) and current head record
//   full, empty     status, derived from the registered count
//   count           records currently stored
module trace_fifo #(
  parameter int  WIDTH = 122,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the count at the start of the cycle, so a pop in the
  // same cycle never frees room for a push.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/trace_capture.sv
// Instruction trace capture: arms, triggers on PC match (or any instruction),
// records CAP_LEN consecutive instructions into a FIFO and streams each
// record out as four 32-bit words over valid/ready.
// Ports:
//   clk, reset                 clock, async active-low reset
//   i_arm, i_trig_any, i_trig_pc   arming and trigger control
//   i_pc, i_inst, i_rd_wen, i_wb_data, i_mem_we, i_mem_wdata  core debug bus
//   o_valid, i_ready, o_data, o_last   output word stream
//   o_state, o_overflow, o_count       status
//
// state   | meaning
// IDLE    | waiting for i_arm
// ARMED   | timestamp running, comparing each PC against the trigger
// CAPTURE | one capture attempt per cycle until CAP_LEN attempts made
// DONE    | capture finished, waiting for the FIFO to drain
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CAP_LEN = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_arm,
  input  logic                         i_trig_any,
  input  logic [31:0]                  i_trig_pc,
  input  logic [31:0]                  i_pc,
  input  logic [31:0]                  i_inst,
  input  logic                         i_rd_wen,
  input  logic [31:0]                  i_wb_data,
  input  logic                         i_mem_we,
  input  logic [31:0]                  i_mem_wdata,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [31:0]                  o_data,
  output logic                         o_last,
  output logic [1:0]                   o_state,
  output logic                         o_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam logic [15:0] CAP_LAST  = 16'(CAP_LEN - 1);
  localparam logic [1:0]  LAST_WORD = 2'(WORDS_PER_REC - 1);

  state_t           state;
  state_t           state_nx;
  logic [TS_W-1:0]  ts;
  logic [15:0]      cap_cnt;
  logic [1:0]       word_idx;
  logic             trig_hit;
  logic             cap_last;
  logic             attempt;
  logic             arm_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic             xfer;
  logic             pop;
  trace_rec_t       rec_in;
  logic [REC_W-1:0] head_bits;
  trace_rec_t       head;

  assign trig_hit = i_trig_any || (i_pc == i_trig_pc);
  // cap_cnt holds attempts already made, so this cycle's attempt is the last.
  assign cap_last = (cap_cnt == CAP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_arm) state_nx = ARMED;
      ARMED:   if (trig_hit) state_nx = cap_last ? DONE : CAPTURE;
      CAPTURE: if (cap_last) state_nx = DONE;
      DONE:    if (fifo_empty && word_idx == 2'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    attempt = 1'b0;
    arm_ok  = 1'b0;
    case (state)
      IDLE:    arm_ok  = i_arm;
      ARMED:   attempt = trig_hit;
      CAPTURE: attempt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts         <= '0;
      cap_cnt    <= '0;
      o_overflow <= 1'b0;
      word_idx   <= '0;
    end else begin
      if (arm_ok) begin
        ts         <= '0;
        cap_cnt    <= '0;
        o_overflow <= 1'b0;
      end else if (state != IDLE) begin
        ts <= ts + TS_W'(1);
      end
      if (attempt) begin
        cap_cnt <= cap_cnt + 16'd1;
        if (fifo_full) o_overflow <= 1'b1;
      end
      if (xfer) word_idx <= (word_idx == LAST_WORD) ? 2'd0 : word_idx + 2'd1;
    end
  end

  always_comb begin
    rec_in.pc     = i_pc;
    rec_in.inst   = i_inst;
    rec_in.data   = i_rd_wen ? i_wb_data : (i_mem_we ? i_mem_wdata : 32'd0);
    rec_in.ts     = ts;
    rec_in.mem_we = i_mem_we;
    rec_in.rd_wen = i_rd_wen;
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (attempt),
    .push_data (rec_in),
    .pop       (pop),
    .head      (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_count)
  );

  assign head    = trace_rec_t'(head_bits);
  assign o_valid = !fifo_empty;
  assign xfer    = o_valid && i_ready;
  assign pop     = xfer && (word_idx == LAST_WORD);
  // Gate with valid so the stream reads 0 when empty (memory is not reset).
  assign o_data  = o_valid ? rec_word(head, word_idx) : 32'd0;
  assign o_last  = o_valid && (word_idx == LAST_WORD);
  assign o_state = state;

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

  localparam int DEPTH   = 16;
  localparam int CAP_LEN = 20;
  localparam int CW      = $clog2(DEPTH + 1);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] data;
    logic [23:0] ts;
    logic        mem_we;
    logic        rd_wen;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          i_arm;
  logic          i_trig_any;
  logic [31:0]   i_trig_pc;
  logic [31:0]   i_pc;
  logic [31:0]   i_inst;
  logic          i_rd_wen;
  logic [31:0]   i_wb_data;
  logic          i_mem_we;
  logic [31:0]   i_mem_wdata;
  logic          o_valid;
  logic          i_ready;
  logic [31:0]   o_data;
  logic          o_last;
  logic [1:0]    o_state;
  logic          o_overflow;
  logic [CW-1:0] o_count;

  trace_capture #(.DEPTH(DEPTH), .CAP_LEN(CAP_LEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_arm       (i_arm),
    .i_trig_any  (i_trig_any),
    .i_trig_pc   (i_trig_pc),
    .i_pc        (i_pc),
    .i_inst      (i_inst),
    .i_rd_wen    (i_rd_wen),
    .i_wb_data   (i_wb_data),
    .i_mem_we    (i_mem_we),
    .i_mem_wdata (i_mem_wdata),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_last      (o_last),
    .o_state     (o_state),
    .o_overflow  (o_overflow),
    .o_count     (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          widx = 0;
  int          recs_out = 0;
  int          pushes = 0;
  int          drops = 0;
  logic [23:0] ts_ref = '0;
  logic        exp_ovf = 1'b0;
  logic        stall_pending = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  logic        grab = 1'b0;
  logic [31:0] got [4];

  function automatic logic [31:0] word_of(input exp_t r, input int idx);
    case (idx)
      0:       return r.pc;
      1:       return r.inst;
      2:       return r.data;
      default: return {r.ts, 6'b000000, r.mem_we, r.rd_wen};
    endcase
  endfunction

  // One core cycle: checks the stream against the scoreboard, then models
  // this cycle's capture attempt, then advances past the rising edge.
  task automatic tick(input bit attempt);
    bit          full_start;
    exp_t        r;
    logic [31:0] exp_w;
    @(negedge clk);
    full_start = (sb.size() >= DEPTH);
    if (stall_pending) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== held_data || o_last !== held_last) begin
        errors++;
        $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                 o_valid, o_data, o_last, held_data, held_last);
      end
    end
    checks++;
    if (o_valid !== (sb.size() != 0)) begin
      errors++;
      $display("FAIL valid got %b exp %b", o_valid, sb.size() != 0);
    end
    checks++;
    if (o_count !== CW'(sb.size())) begin
      errors++;
      $display("FAIL count got %0d exp %0d", o_count, sb.size());
    end
    checks++;
    if (o_overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow got %b exp %b", o_overflow, exp_ovf);
    end
    if (o_valid && i_ready && sb.size() != 0) begin
      exp_w = word_of(sb[0], widx);
      checks++;
      if (o_data !== exp_w) begin
        errors++;
        $display("FAIL word%0d got %h exp %h", widx, o_data, exp_w);
      end
      checks++;
      if (o_last !== (widx == 3)) begin
        errors++;
        $display("FAIL last got %b exp %b", o_last, widx == 3);
      end
      if (grab) got[widx] = o_data;
      if (widx == 3) begin
        void'(sb.pop_front());
        recs_out++;
        widx = 0;
        grab = 1'b0;
      end else begin
        widx++;
      end
    end
    stall_pending = o_valid && !i_ready;
    held_data = o_data;
    held_last = o_last;
    if (attempt) begin
      r.pc = i_pc; r.inst = i_inst; r.ts = ts_ref;
      r.mem_we = i_mem_we; r.rd_wen = i_rd_wen;
      r.data = i_rd_wen ? i_wb_data : (i_mem_we ? i_mem_wdata : 32'd0);
      if (full_start) begin
        exp_ovf = 1'b1;
        drops++;
      end else begin
        sb.push_back(r);
        pushes++;
      end
    end
    @(posedge clk);
    #1;
    ts_ref = ts_ref + 24'd1;
  endtask

  task automatic set_instr(input logic [31:0] pc);
    i_pc = pc;
    i_inst = $urandom;
    i_rd_wen = 1'b1;
    i_wb_data = $urandom;
    i_mem_we = 1'b0;
    i_mem_wdata = $urandom;
  endtask

  task automatic do_arm(input bit any, input logic [31:0] tpc);
    i_trig_any = any;
    i_trig_pc = tpc;
    i_pc = 32'hFFFF_FF00;
    i_arm = 1'b1;
    tick(0);
    i_arm = 1'b0;
    ts_ref = '0;
    exp_ovf = 1'b0;
    recs_out = 0; pushes = 0; drops = 0;
    checks++;
    if (o_state !== 2'd1) begin
      errors++;
      $display("FAIL arm_state got %0d exp 1", o_state);
    end
  endtask

  task automatic drain(input bit toggle);
    int n = 0;
    i_pc = 32'hFFFF_FF00;
    while (!(sb.size() == 0 && o_state == 2'd0) && n < 400) begin
      if (toggle) i_ready = ~i_ready;
      tick(0);
      n++;
    end
    i_ready = 1'b1;
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL drain_timeout got %0d cycles exp <400", n);
    end
    checks++;
    if (o_state !== 2'd0) begin
      errors++;
      $display("FAIL drain_state got %0d exp 0", o_state);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    i_arm = 0; i_trig_any = 0; i_trig_pc = 0; i_ready = 1;
    set_instr(32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 0 || o_data !== 0 || o_last !== 0 || o_state !== 0 ||
        o_overflow !== 0 || o_count !== 0) begin
      errors++;
      $display("FAIL reset_vals got v=%b d=%h l=%b s=%0d ov=%b c=%0d exp all 0",
               o_valid, o_data, o_last, o_state, o_overflow, o_count);
    end
    @(negedge clk);
    reset = 1'b1;
    tick(0);
    checks++;
    if (o_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle got %0d exp 0", o_state);
    end
  endtask

  task automatic test_trig_any;
    i_ready = 1'b1;
    do_arm(1'b1, 32'h0);
    for (int i = 0; i < CAP_LEN; i++) begin
      set_instr(32'(4 * i));
      tick(1);
      if (i == 0) begin
        checks++;
        if (o_state !== 2'd2) begin
          errors++;
          $display("FAIL any_capture_state got %0d exp 2", o_state);
        end
      end
    end
    checks++;
    if (o_state !== 2'd3) begin
      errors++;
      $display("FAIL any_done_state got %0d exp 3", o_state);
    end
    drain(0);
    checks++;
    if (recs_out !== CAP_LEN) begin
      errors++;
      $display("FAIL any_records got %0d exp %0d", recs_out, CAP_LEN);
    end
  endtask

  task automatic test_trig_pc;
    i_ready = 1'b1;
    grab = 1'b1;
    do_arm(1'b0, 32'h10);
    for (int i = 0; i < 4 + CAP_LEN + 2; i++) begin
      set_instr(32'(4 * i));
      tick((i >= 4) && (i < 4 + CAP_LEN));
      if (i == 3) begin
        checks++;
        if (o_state !== 2'd1) begin
          errors++;
          $display("FAIL pc_still_armed got %0d exp 1", o_state);
        end
      end
    end
    drain(0);
    checks++;
    if (got[0] !== 32'h10) begin
      errors++;
      $display("FAIL pc_first got %h exp 00000010", got[0]);
    end
    checks++;
    if (got[3][31:8] !== 24'd4) begin
      errors++;
      $display("FAIL pc_ts got %0d exp 4", got[3][31:8]);
    end
  endtask

  task automatic test_overflow;
    i_ready = 1'b0;
    do_arm(1'b1, 32'h0);
    for (int i = 0; i < CAP_LEN; i++) begin
      set_instr(32'h1000 + 32'(4 * i));
      tick(1);
    end
    checks++;
    if (o_count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL ovf_count got %0d exp %0d", o_count, DEPTH);
    end
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got %b exp 1", o_overflow);
    end
    i_ready = 1'b1;
    drain(0);
    checks++;
    if (recs_out !== DEPTH) begin
      errors++;
      $display("FAIL ovf_records got %0d exp %0d", recs_out, DEPTH);
    end
  endtask

  task automatic test_toggle;
    do_arm(1'b1, 32'h0);
    for (int i = 0; i < CAP_LEN; i++) begin
      i_ready = i[0];
      set_instr(32'h2000 + 32'(4 * i));
      tick(1);
    end
    drain(1);
    checks++;
    if (recs_out !== pushes || pushes + drops !== CAP_LEN) begin
      errors++;
      $display("FAIL toggle_records got %0d exp %0d", recs_out, pushes);
    end
  endtask

  task automatic test_store;
    i_ready = 1'b1;
    grab = 1'b1;
    do_arm(1'b1, 32'h0);
    for (int i = 0; i < CAP_LEN; i++) begin
      set_instr(32'h3000 + 32'(4 * i));
      case (i % 3)
        0: begin
          i_rd_wen = 1'b0; i_mem_we = 1'b1;
          i_mem_wdata = 32'hDEADBEEF; i_wb_data = 32'h12345678;
        end
        1: begin i_rd_wen = 1'b1; i_mem_we = 1'b1; end
        default: begin i_rd_wen = 1'b0; i_mem_we = 1'b0; end
      endcase
      tick(1);
    end
    drain(0);
    checks++;
    if (got[2] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_data got %h exp deadbeef", got[2]);
    end
    checks++;
    if (got[3][1:0] !== 2'b10) begin
      errors++;
      $display("FAIL store_flags got %b exp 10", got[3][1:0]);
    end
  endtask

  task automatic test_reset_mid;
    i_ready = 1'b1;
    do_arm(1'b1, 32'h0);
    set_instr(32'h4000); tick(1);
    set_instr(32'h4004); tick(1);
    checks++;
    if (widx !== 1) begin
      errors++;
      $display("FAIL mid_widx got %0d exp 1", widx);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (o_valid !== 0 || o_count !== 0 || o_state !== 0 || o_data !== 0 || o_last !== 0) begin
      errors++;
      $display("FAIL mid_reset got v=%b c=%0d s=%0d d=%h l=%b exp all 0",
               o_valid, o_count, o_state, o_data, o_last);
    end
    sb.delete();
    widx = 0;
    stall_pending = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_instr(32'h4100 + 32'(4 * i));
      tick(0);
    end
    checks++;
    if (o_state !== 2'd0 || o_count !== 0) begin
      errors++;
      $display("FAIL mid_after got s=%0d c=%0d exp s=0 c=0", o_state, o_count);
    end
  endtask

  initial begin
    test_reset();
    test_trig_any();
    test_trig_pc();
    test_overflow();
    test_toggle();
    test_store();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
# trace_capture

Instruction trace capture unit that sits directly downstream of the single-cycle core and consumes its per-cycle debug outputs (PC, instruction, write-back, memory-write signals). After arming and a PC-match trigger, it records a fixed number of consecutive retired instructions into an on-chip FIFO. It drains the FIFO as a stream of 32-bit words over a valid/ready interface for a host or UART bridge.

## Interface
Parameters:
- DEPTH, 16, FIFO capacity in records (power of two, ≥2)
- CAP_LEN, 64, records attempted per capture window (1..65535)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- i_arm  in  1  one-cycle arm request; honoured only in IDLE
- i_trig_any  in  1  1: trigger on first instruction after arming; 0: trigger on PC match
- i_trig_pc  in  32  trigger PC, sampled each cycle in ARMED
- i_pc  in  32  core PC of the instruction executing this cycle
- i_inst  in  32  instruction word
- i_rd_wen  in  1  core register write enable
- i_wb_data  in  32  core write-back value
- i_mem_we  in  1  core data-memory write enable
- i_mem_wdata  in  32  store data (core regData2)
- o_valid  out  1  output word valid
- i_ready  in  1  consumer accepts word
- o_data  out  32  output word
- o_last  out  1  high on final word (word 3) of a record
- o_state  out  2  current state encoding
- o_overflow  out  1  sticky: ≥1 record dropped on full FIFO
- o_count  out  $clog2(DEPTH+1)  records currently stored

## Operation
- States: IDLE(0), ARMED(1), CAPTURE(2), DONE(3).
- IDLE + i_arm=1 -> ARMED; clears o_overflow, capture counter, and 24-bit timestamp. i_arm is ignored in all other states.
- ARMED: trigger when i_trig_any=1 or i_pc==i_trig_pc. The triggering instruction is the first record captured, and the state moves to CAPTURE.
- CAPTURE: each cycle is one retired instruction and one capture attempt. After CAP_LEN attempts (triggering one included), move to DONE.
- A record is pushed if the FIFO is not full at the start of the cycle. Otherwise it is dropped and o_overflow is set. A simultaneous pop does not rescue a push when full. Dropped records still count toward CAP_LEN.
- Record data field: i_wb_data if i_rd_wen; else i_mem_wdata if i_mem_we; else 0.
- Timestamp: free-running 24-bit cycle counter from arming. It increments every cycle outside IDLE and wraps 0xFFFFFF -> 0.
- Serialization per record, in order:
  - word0 = pc
  - word1 = inst
  - word2 = data
  - word3 = {timestamp[23:0], 6'b0, mem_we, rd_wen}
- A record is popped on the word3 handshake.
- Draining runs in every state whenever the FIFO is non-empty.
- DONE -> IDLE when the FIFO is empty and no record is mid-serialization.

## Timing
- Reset values (async, effective immediately):
  - o_valid=0, o_data=0, o_last=0
  - o_state=IDLE, o_overflow=0, o_count=0
  - FIFO pointers, word index, capture counter, and timestamp all 0
- Trigger compare and capture are combinational on the inputs of the current cycle. The push is registered at that cycle's rising edge, which is the same edge the core updates its PC.
- Latency: o_valid rises in the cycle after the push edge when the FIFO was empty.
- Handshake: a transfer occurs on an edge with o_valid && i_ready. While o_valid=1 && i_ready=0, o_data and o_last are held stable. o_valid never drops without a transfer.
- Back-to-back: with i_ready held high, one word transfers per cycle, so one record takes 4 cycles.
- o_count updates on the edge of a push or pop; a simultaneous push and pop leaves it unchanged.
- Reset asserted mid-capture or mid-record discards all contents; no partial record is emitted afterwards.

## Structure
- Package trace_pkg holds:
  - state enum (IDLE, ARMED, CAPTURE, DONE)
  - packed record struct {pc, inst, data, ts[23:0], mem_we, rd_wen} (122 bits)
  - WORDS_PER_REC=4 and TS_W=24
- Sub-module trace_fifo: synchronous single-clock FIFO of records, width and depth parameterized, with full/empty/count outputs. It uses the same clk and async active-low reset.
- Top level: FSM, timestamp, capture counter, and a 2-bit word-index serializer.

## Test plan
- Arm with i_trig_any=1, CAP_LEN=4, i_ready=1, with 4 instructions at PCs 0x0, 0x4, 0x8, 0xC -> 16 words; word0 values are 0x0..0xC, o_last on every 4th word, then o_state returns to IDLE.
- Arm with i_trig_pc=0x10 while the PC steps 0x0..0x20 -> the first captured pc is 0x10, and the timestamp in word3 equals the cycles elapsed since arming.
- DEPTH=16, CAP_LEN=20, i_ready=0 -> o_count saturates at 16, o_overflow=1, and exactly 16 records drain after i_ready=1.
- i_ready toggled 1/0 every cycle -> no word lost or duplicated, and o_data is stable while stalled.
- Store with i_mem_we=1, i_mem_wdata=0xDEADBEEF, i_rd_wen=0 -> word2=0xDEADBEEF and word3[1:0]=2'b10.
- Assert reset low during word1 of a record -> o_valid=0 immediately, and after release o_state=IDLE with o_count=0.
